// File: rtl/icache_pkg.sv
// icache_pkg: shared state type, default geometry and address-field helpers
// for icache_responder (optional flush port: ICACHE_FLUSH_EN).
package icache_pkg;
    localparam int XLEN           = 32;
    localparam int DEF_LINES      = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int OFF_W          = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W          = $clog2(DEF_LINES);
    localparam int TAG_W          = XLEN - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } state_t;

    function automatic logic [XLEN-1:0] f_mask(input int w);
        return (XLEN'(1) << w) - XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] f_off(
        input logic [XLEN-1:0] a,
        input int              ow
    );
        return (a >> 2) & f_mask(ow);
    endfunction

    function automatic logic [XLEN-1:0] f_idx(
        input logic [XLEN-1:0] a,
        input int              ow,
        input int              iw
    );
        return (a >> (2 + ow)) & f_mask(iw);
    endfunction

    function automatic logic [XLEN-1:0] f_tag(
        input logic [XLEN-1:0] a,
        input int              ow,
        input int              iw
    );
        return a >> (2 + ow + iw);
    endfunction

    function automatic logic [XLEN-1:0] f_base(
        input logic [XLEN-1:0] a,
        input int              ow
    );
        return a & ~f_mask(ow + 2);
    endfunction
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side lookup and backing-memory read port of the
// instruction cache; slave = cache side, master = fetch/memory side.
interface icache_if;
    import icache_pkg::*;

    logic [XLEN-1:0] icache_addr;
    logic [XLEN-1:0] icache_data;
    logic            icache_rdy;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;

    modport slave (
        input  icache_addr,
        output icache_data,
        output icache_rdy,
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport master (
        output icache_addr,
        input  icache_data,
        input  icache_rdy,
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: line-refill sequencer; owns state, beat counter,
// the latched line base/idx/tag and the memory request.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    parameter  int IDX_BITS   = IDX_W,
    parameter  int TAG_BITS   = TAG_W,
    localparam int OFF_BITS   = $clog2(LINE_WORDS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_miss,
    input  logic [XLEN-1:0]     i_addr,
    input  logic [IDX_BITS-1:0] i_idx,
    input  logic [TAG_BITS-1:0] i_tag,
    input  logic                i_flush,
    input  logic                i_rvalid,
    input  logic [XLEN-1:0]     i_rdata,
    output state_t              o_state,
    output logic                o_mem_req,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic                o_wr_en,
    output logic [IDX_BITS-1:0] o_wr_idx,
    output logic [OFF_BITS-1:0] o_wr_beat,
    output logic [XLEN-1:0]     o_wr_data,
    output logic [TAG_BITS-1:0] o_wr_tag,
    output logic                o_set_valid,
    output logic                o_flush_all
);
    state_t                r_state;
    logic [OFF_BITS-1:0]   r_beat;
    logic [XLEN-1:0]       r_base;
    logic [IDX_BITS-1:0]   r_idx;
    logic [TAG_BITS-1:0]   r_tag;
    logic                  r_flush_pend;

    state_t                w_state_nx;
    logic [OFF_BITS-1:0]   w_beat_nx;
    logic [XLEN-1:0]       w_base_nx;
    logic [IDX_BITS-1:0]   w_idx_nx;
    logic [TAG_BITS-1:0]   w_tag_nx;
    logic                  w_pend_nx;
    logic                  w_last;

    assign w_last    = (r_beat == OFF_BITS'(LINE_WORDS - 1));
    assign o_state   = r_state;
    assign o_wr_idx  = r_idx;
    assign o_wr_beat = r_beat;
    assign o_wr_data = i_rdata;
    assign o_wr_tag  = r_tag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_tag        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_beat       <= w_beat_nx;
            r_base       <= w_base_nx;
            r_idx        <= w_idx_nx;
            r_tag        <= w_tag_nx;
            r_flush_pend <= w_pend_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_beat_nx   = r_beat;
        w_base_nx   = r_base;
        w_idx_nx    = r_idx;
        w_tag_nx    = r_tag;
        w_pend_nx   = r_flush_pend;
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        o_wr_en     = 1'b0;
        o_set_valid = 1'b0;
        o_flush_all = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_flush_all = i_flush;
                w_pend_nx   = 1'b0;
                if (i_miss) begin
                    w_state_nx = REFILL;
                    w_beat_nx  = '0;
                    w_base_nx  = f_base(i_addr, OFF_BITS);
                    w_idx_nx   = i_idx;
                    w_tag_nx   = i_tag;
                end
            end
            REFILL: begin
                o_mem_req  = 1'b1;
                // base has zero offset bits, so OR never carries out of the line
                o_mem_addr = r_base | (XLEN'(r_beat) << 2);
                w_pend_nx  = r_flush_pend | i_flush;
                if (i_rvalid) begin
                    o_wr_en   = 1'b1;
                    w_beat_nx = r_beat + 1'b1;
                    if (w_last) begin
                        w_state_nx  = DONE;
                        o_set_valid = !w_pend_nx;
                        o_flush_all = w_pend_nx;
                    end
                end
            end
            DONE: begin
                w_state_nx = IDLE;
                w_pend_nx  = 1'b0;
            end
            default: w_state_nx = IDLE;
        endcase
    end
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only instruction cache, zero-latency
// hits, line refill on miss. `define ICACHE_FLUSH_EN adds the flush port.
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic clock,
    input  logic reset,
`ifdef ICACHE_FLUSH_EN
    input  logic flush,
`endif
    icache_if.slave bus
);
    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = XLEN - 2 - OFF_BITS - IDX_BITS;

    logic [XLEN-1:0]     r_data [LINES][LINE_WORDS];
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [LINES-1:0]    r_valid;

    logic [OFF_BITS-1:0] w_off;
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic                w_idle;
    logic                w_miss;
    logic                w_rdy;
    logic                w_flush;
    state_t              w_state;
    logic                w_wr_en;
    logic [IDX_BITS-1:0] w_wr_idx;
    logic [OFF_BITS-1:0] w_wr_beat;
    logic [XLEN-1:0]     w_wr_data;
    logic [TAG_BITS-1:0] w_wr_tag;
    logic                w_set_valid;
    logic                w_flush_all;

`ifdef ICACHE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_off  = OFF_BITS'(f_off(bus.icache_addr, OFF_BITS));
    assign w_idx  = IDX_BITS'(f_idx(bus.icache_addr, OFF_BITS, IDX_BITS));
    assign w_tag  = TAG_BITS'(f_tag(bus.icache_addr, OFF_BITS, IDX_BITS));
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle = (w_state == IDLE);
    assign w_miss = w_idle && !w_hit && !w_flush;
    assign w_rdy  = w_idle && w_hit && !w_flush;

    assign bus.icache_rdy  = w_rdy;
    assign bus.icache_data = w_rdy ? r_data[w_idx][w_off] : '0;

    icache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_BITS   (IDX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_fsm (
        .clock       (clock),
        .reset       (reset),
        .i_miss      (w_miss),
        .i_addr      (bus.icache_addr),
        .i_idx       (w_idx),
        .i_tag       (w_tag),
        .i_flush     (w_flush),
        .i_rvalid    (bus.mem_rvalid),
        .i_rdata     (bus.mem_rdata),
        .o_state     (w_state),
        .o_mem_req   (bus.mem_req),
        .o_mem_addr  (bus.mem_addr),
        .o_wr_en     (w_wr_en),
        .o_wr_idx    (w_wr_idx),
        .o_wr_beat   (w_wr_beat),
        .o_wr_data   (w_wr_data),
        .o_wr_tag    (w_wr_tag),
        .o_set_valid (w_set_valid),
        .o_flush_all (w_flush_all)
    );

    // a line is invalidated on miss so a half-written line never hits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_flush_all) begin
            r_valid <= '0;
        end else begin
            if (w_miss)
                r_valid[w_idx] <= 1'b0;
            if (w_set_valid)
                r_valid[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en)
            r_data[w_wr_idx][w_wr_beat] <= w_wr_data;
        if (w_set_valid)
            r_tag[w_wr_idx] <= w_wr_tag;
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scoreboard bench for icache_responder
// with a latency-programmable backing-memory responder.
module tb_icache_responder;
    logic clock = 1'b0;
    logic reset;
`ifdef ICACHE_FLUSH_EN
    logic flush;
`endif

    icache_if bus_if ();

    icache_responder dut (
        .clock (clock),
        .reset (reset),
`ifdef ICACHE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat   = 0;
    int          rsp_cnt = 0;
    int          wn;
    logic [31:0] act_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] exp_dq [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11;
            32'h104: return 32'h22;
            32'h108: return 32'h33;
            32'h10C: return 32'h44;
            default: return a ^ 32'hC3C3_0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory model: answers each request after lat idle cycles
    initial begin
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
        forever begin
            @(negedge clock);
            if (bus_if.mem_req !== 1'b1) begin
                bus_if.mem_rvalid = 1'b0;
                rsp_cnt = 0;
            end else begin
                if (bus_if.mem_rvalid)
                    rsp_cnt = 0;
                if (rsp_cnt >= lat) begin
                    bus_if.mem_rvalid = 1'b1;
                    bus_if.mem_rdata  = mem_word(bus_if.mem_addr);
                    act_q.push_back(bus_if.mem_addr);
                end else begin
                    bus_if.mem_rvalid = 1'b0;
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic expect_line(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(b + 32'(4 * k));
    endtask

    task automatic drain(input string tag);
        logic [31:0] e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (act_q.size() > 0) ? act_q.pop_front() : 32'hDEAD_BEEF;
            chk({tag, "_maddr"}, o, e);
        end
        chk({tag, "_extra"}, 32'(act_q.size()), 32'd0);
        act_q.delete();
    endtask

    task automatic wait_rdy(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (bus_if.icache_rdy !== 1'b1 && n < 300) begin
            @(negedge clock);
            #2;
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus_if.icache_rdy), 32'd1);
        chk({tag, "_data"}, bus_if.icache_data, exp_dq.pop_front());
        if (exp_cyc >= 0)
            chk({tag, "_cyc"}, 32'(n), 32'(exp_cyc));
    endtask

    task automatic fetch(input string tag, input logic [31:0] a,
                         input int exp_cyc);
        exp_dq.push_back(mem_word(a));
        @(negedge clock);
        #1;
        bus_if.icache_addr = a;
        #1;
        wait_rdy(tag, exp_cyc);
    endtask

    initial begin
        reset = 1'b1;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        bus_if.icache_addr = 32'h100;
        repeat (2) @(negedge clock);
        #2;
        chk("rst_rdy", 32'(bus_if.icache_rdy), 32'd0);
        chk("rst_data", bus_if.icache_data, 32'd0);
        chk("rst_mreq", 32'(bus_if.mem_req), 32'd0);
        chk("rst_maddr", bus_if.mem_addr, 32'd0);

        // cold miss, 0-cycle memory
        expect_line(32'h100);
        exp_dq.push_back(mem_word(32'h100));
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        wait_rdy("cold", 6);
        drain("cold");

        // back-to-back hits
        fetch("hit0", 32'h10C, 0);
        chk("hit0_mreq", 32'(bus_if.mem_req), 32'd0);
        fetch("hit1", 32'h104, 0);
        chk("hit1_mreq", 32'(bus_if.mem_req), 32'd0);
        chk("hit_noreq", 32'(act_q.size()), 32'd0);

        // conflict eviction on idx 16
        expect_line(32'h500);
        fetch("evict", 32'h500, 6);
        expect_line(32'h100);
        fetch("reload", 32'h100, 6);
        drain("conflict");

        // jump during a slow refill
        lat = 3;
        expect_line(32'h200);
        expect_line(32'h300);
        exp_dq.push_back(mem_word(32'h300));
        @(negedge clock);
        #1;
        bus_if.icache_addr = 32'h200;
        wn = 0;
        while (act_q.size() < 2 && wn < 100) begin
            @(negedge clock);
            #2;
            wn++;
        end
        bus_if.icache_addr = 32'h300;
        wait_rdy("jump", -1);
        drain("jump");
        fetch("jump_old", 32'h200, 0);

        // reset while refilling
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        @(negedge clock);
        #1;
        bus_if.icache_addr = 32'h400;
        wn = 0;
        while (act_q.size() < 3 && wn < 100) begin
            @(negedge clock);
            #2;
            wn++;
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_mreq", 32'(bus_if.mem_req), 32'd0);
        chk("rstmid_rdy", 32'(bus_if.icache_rdy), 32'd0);
        drain("rstmid_part");
        lat = 0;
        expect_line(32'h400);
        exp_dq.push_back(mem_word(32'h400));
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        wait_rdy("rstmid", 6);
        drain("rstmid");

        // line at the top of the address space
        expect_line(32'hFFFF_FFF8);
        fetch("wrap", 32'hFFFF_FFF8, 6);
        drain("wrap");

        // earlier lines were dropped by reset
        expect_line(32'h100);
        fetch("post_rst", 32'h100, 6);
        drain("post_rst");
        fetch("post_hit", 32'h108, 0);

`ifdef ICACHE_FLUSH_EN
        @(negedge clock);
        #1;
        bus_if.icache_addr = 32'h100;
        flush = 1'b1;
        #1;
        chk("flush_rdy", 32'(bus_if.icache_rdy), 32'd0);
        expect_line(32'h100);
        exp_dq.push_back(mem_word(32'h100));
        @(negedge clock);
        #1;
        flush = 1'b0;
        #1;
        wait_rdy("flush", 6);
        drain("flush");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
